// File: rtl/decoder_param_stream_if.sv
// Stream bundle for decoder_param_stream: producer side (in_*) and consumer side (out_*).
// in_thermo is present only when DECODER_PARAM_THERMO_EN is defined.
interface decoder_param_stream_if #(
  parameter int BITS = 6,
  parameter int SIZE = 40
) ();
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_idx;
  logic            in_acc;
`ifdef DECODER_PARAM_THERMO_EN
  logic            in_thermo;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_vec;
  logic            out_oor;

  modport slave (
`ifdef DECODER_PARAM_THERMO_EN
    input  in_thermo,
`endif
    input  in_valid, in_idx, in_acc, out_ready,
    output in_ready, out_valid, out_vec, out_oor
  );

  modport master (
`ifdef DECODER_PARAM_THERMO_EN
    output in_thermo,
`endif
    output in_valid, in_idx, in_acc, out_ready,
    input  in_ready, out_valid, out_vec, out_oor
  );
endinterface

// File: rtl/decoder_param_stream.sv
// Registered index-to-one-hot decoder behind a valid/ready stream with a 2-entry skid buffer,
// plus a sticky accumulated mask and popcount. Thermometer decode under DECODER_PARAM_THERMO_EN.
module decoder_param_stream #(
  parameter int BITS = 6,
  parameter int SIZE = 40,
  parameter int CNTW = BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_param_stream_if.slave bus,
  input  logic                 acc_clr_valid,
  input  logic [BITS-1:0]      acc_clr_idx,
  output logic [SIZE-1:0]      acc_mask,
  output logic [CNTW-1:0]      acc_count
);

  typedef struct packed {
    logic [SIZE-1:0] vec;
    logic            oor;
    logic            acc;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam logic [BITS:0] SIZE_W = (BITS+1)'(SIZE);

  function automatic entry_t decode(input logic [BITS-1:0] idx, input logic thermo,
                                    input logic acc);
    entry_t e;
    e     = '0;
    e.oor = {1'b0, idx} >= SIZE_W;
    e.acc = acc;
    for (int i = 0; i < SIZE; i++) begin
      e.vec[i] = thermo ? ({1'b0, idx} >= (BITS+1)'(i)) : ({1'b0, idx} == (BITS+1)'(i));
    end
    return e;
  endfunction

  function automatic logic [CNTW-1:0] popcount(input logic [SIZE-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < SIZE; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction

  entry_t          out_q, out_d;
  logic            out_valid_q, out_valid_d;
  entry_t          skid_q [2];
  entry_t          skid_d [2];
  occ_t            occ_q, occ_d;
  logic            in_ready_q, in_ready_d;
  logic [SIZE-1:0] acc_mask_q, acc_mask_d;
  logic [CNTW-1:0] acc_count_q, acc_count_d;

  logic            thermo, accept, drain, pop, direct, push;
  logic [1:0]      occ_n;
  logic [SIZE-1:0] set_vec, clr_vec;
  entry_t          new_e;

  always_comb begin
`ifdef DECODER_PARAM_THERMO_EN
    thermo = bus.in_thermo;
`else
    thermo = 1'b0;
`endif
    new_e  = decode(bus.in_idx, thermo, bus.in_acc);
    accept = bus.in_valid && in_ready_q;
    drain  = out_valid_q && bus.out_ready;
    pop    = drain && (occ_q != OCC_EMPTY);
    // A new entry bypasses the skid only when nothing older is waiting ahead of it.
    direct = accept && (occ_q == OCC_EMPTY) && (!out_valid_q || drain);
    push   = accept && !direct;

    // NOTE: every comb output gets a default before any conditional update, so no latch is inferred.
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    occ_n       = occ_q;

    if (drain) out_valid_d = 1'b0;
    if (pop) begin
      out_d       = skid_q[0];
      out_valid_d = 1'b1;
      skid_d[0]   = skid_q[1];
      occ_n       = occ_n - 2'd1;
    end else if (direct) begin
      out_d       = new_e;
      out_valid_d = 1'b1;
    end
    if (push) begin
      skid_d[occ_n[0]] = new_e;
      occ_n            = occ_n + 2'd1;
    end
    occ_d      = occ_t'(occ_n);
    in_ready_d = (occ_d != OCC_FULL);

    set_vec = (drain && out_q.acc && !out_q.oor) ? out_q.vec : '0;
    for (int i = 0; i < SIZE; i++) begin
      clr_vec[i] = acc_clr_valid && ({1'b0, acc_clr_idx} == (BITS+1)'(i));
    end
    // Set is applied after clear so a same-cycle set and clear leaves the bit at 1.
    acc_mask_d  = (acc_mask_q & ~clr_vec) | set_vec;
    acc_count_d = popcount(acc_mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      // NOTE: skid payload is reset too; occupancy alone marks validity, but this keeps X out of the datapath.
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      acc_mask_q  <= '0;
      acc_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      acc_mask_q  <= acc_mask_d;
      acc_count_q <= acc_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_q.vec;
  assign bus.out_oor   = out_q.oor;
  assign acc_mask      = acc_mask_q;
  assign acc_count     = acc_count_q;

endmodule
